// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master engine; macro I2C_CLOCK_STRETCH_EN enables slave clock stretching
module i2c_byte_master #(
    parameter int P_CLK_DIVIDER = 125
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_CMD_VALID,
    input  logic [1:0] I_CMD,
    input  logic [7:0] I_DATA,
    input  logic       I_ACK,
    output logic       O_CMD_READY,
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic [7:0] O_DATA,
    output logic       O_ACK_RECEIVED,
    input  logic       I_SCL,
    input  logic       I_SDA,
    output logic       O_SCL_OE,
    output logic       O_SDA_OE
);
    localparam int CW = $clog2(P_CLK_DIVIDER);
    localparam logic [CW-1:0] Q_LAST = CW'(P_CLK_DIVIDER - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [1:0]      phase_q;
    logic [CW-1:0]   qcnt_q;
    logic [CW-1:0]   qcnt_d;
    logic [3:0]      bit_q;
    logic [3:0]      bit_d;
    logic [7:0]      tx_q;
    logic [7:0]      rx_q;
    logic            rd_q;
    logic            ack_q;
    logic            ack_smp_q;
    logic            scl_oe_q;
    logic            sda_oe_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      data_q;
    logic            ack_rx_q;
    logic            scl_meta_q;
    logic            scl_sync_q;
    logic            sda_meta_q;
    logic            sda_sync_q;
    logic            stretch_hold;
    logic            phase_end;
    logic            next_sda_oe;

    assign O_SCL_OE       = scl_oe_q;
    assign O_SDA_OE       = sda_oe_q;
    assign O_CMD_READY    = ready_q;
    assign O_BUSY         = busy_q;
    assign O_DONE         = done_q;
    assign O_DATA         = data_q;
    assign O_ACK_RECEIVED = ack_rx_q;

    // Bring the asynchronous pad levels into the clock domain before any use
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= I_SCL;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= I_SDA;
            sda_sync_q <= sda_meta_q;
        end
    end

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low during the high half of a bit freezes the quarter counter
    assign stretch_hold = (phase_q == 2'd2) && !scl_sync_q;
`else
    assign stretch_hold = 1'b0;
    logic unused_scl;
    assign unused_scl = scl_sync_q;
`endif

    // Quarter-period pacing and the SDA value for the next bit slot
    always_comb begin
        phase_end = (qcnt_q == Q_LAST) && !stretch_hold;
        if (stretch_hold || phase_end) begin
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + CW'(1);
        end
        bit_d = bit_q + 4'd1;
        if (bit_d == 4'd8) begin
            next_sda_oe = rd_q ? ack_q : 1'b0;
        end else begin
            next_sda_oe = rd_q ? 1'b0 : ~tx_q[3'd7 - bit_d[2:0]];
        end
    end

    // Command sequencer: accepts one command, walks its quarter phases, pulses done
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q   <= ST_IDLE;
            phase_q   <= 2'd0;
            qcnt_q    <= '0;
            bit_q     <= 4'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rd_q      <= 1'b0;
            ack_q     <= 1'b0;
            ack_smp_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= 8'h00;
            ack_rx_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    qcnt_q <= '0;
                    if (I_CMD_VALID) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        phase_q <= 2'd0;
                        bit_q   <= 4'd0;
                        tx_q    <= I_DATA;
                        rd_q    <= (I_CMD == CMD_READ);
                        ack_q   <= I_ACK;
                        case (I_CMD)
                            CMD_START: begin
                                state_q  <= ST_START;
                                sda_oe_q <= 1'b0;
                            end
                            CMD_STOP: begin
                                state_q  <= ST_STOP;
                                scl_oe_q <= 1'b1;
                                sda_oe_q <= 1'b1;
                            end
                            CMD_WRITE: begin
                                state_q  <= ST_BIT;
                                scl_oe_q <= 1'b1;
                                sda_oe_q <= ~I_DATA[7];
                            end
                            default: begin
                                state_q  <= ST_BIT;
                                scl_oe_q <= 1'b1;
                                sda_oe_q <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_START: begin
                    qcnt_q <= qcnt_d;
                    if (phase_end) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: sda_oe_q <= 1'b1;
                            2'd2: ;
                            default: begin
                                scl_oe_q <= 1'b1;
                                state_q  <= ST_DONE;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    qcnt_q <= qcnt_d;
                    if (phase_end) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: sda_oe_q <= 1'b0;
                            2'd2: ;
                            default: begin
                                scl_oe_q <= 1'b0;
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_DONE;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_BIT: begin
                    qcnt_q <= qcnt_d;
                    if (phase_end) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: ;
                            2'd1: scl_oe_q <= 1'b0;
                            2'd2: begin
                                // SCL has been high for a full quarter: sample the bus here
                                if (bit_q == 4'd8) begin
                                    ack_smp_q <= ~sda_sync_q;
                                end else if (rd_q) begin
                                    rx_q <= {rx_q[6:0], sda_sync_q};
                                end
                            end
                            default: begin
                                if (bit_q == 4'd8) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    if (rd_q) begin
                                        data_q <= rx_q;
                                    end else begin
                                        ack_rx_q <= ack_smp_q;
                                    end
                                end else begin
                                    bit_q    <= bit_d;
                                    scl_oe_q <= 1'b1;
                                    sda_oe_q <= next_sda_oe;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= 2'd0;
                    qcnt_q  <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - self-checking bench for i2c_byte_master
module tb_i2c_byte_master;
    localparam int P = 4;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] data_in;
    logic       ack_in;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       ack_rx;
    logic       scl_pad;
    logic       sda_pad;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_hold;
    logic       slave_low;

    assign scl_pad = !scl_oe && !scl_hold;
    assign sda_pad = !sda_oe && !slave_low;

    int errors = 0;
    int checks = 0;
    logic cmp_en;

    // bench model state
    int         m_st;
    logic [1:0] m_cmd;
    int         m_k;
    int         m_len;
    logic [7:0] m_tx;
    logic       m_ack;
    logic       e_scl, e_sda, e_ready, e_busy, e_done, e_ackr;
    logic [7:0] e_data;
    logic [7:0] slave_byte;
    logic       slave_ack;

    // monitors
    int         done_cnt = 0;
    logic [8:0] cap_bits;
    logic       cap_prev_scl;
    logic       cap_prev_sda;
    logic       sda_rise_scl;

    i2c_byte_master #(.P_CLK_DIVIDER(P)) dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_CMD_VALID    (cmd_valid),
        .I_CMD          (cmd),
        .I_DATA         (data_in),
        .I_ACK          (ack_in),
        .O_CMD_READY    (cmd_ready),
        .O_BUSY         (busy),
        .O_DONE         (done),
        .O_DATA         (data_out),
        .O_ACK_RECEIVED (ack_rx),
        .I_SCL          (scl_pad),
        .I_SDA          (sda_pad),
        .O_SCL_OE       (scl_oe),
        .O_SDA_OE       (sda_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected line drive for cycle k of the current command, from the bit/phase rules
    task automatic m_lines(input int k);
        int q;
        int ph;
        int b;
        q  = k / P;
        ph = q % 4;
        b  = q / 4;
        case (m_cmd)
            C_START: begin
                if (ph >= 1) e_scl = 1'b0;
                e_sda = (ph >= 2);
            end
            C_STOP: begin
                e_scl = (ph == 0);
                e_sda = (ph < 2);
            end
            default: begin
                e_scl = (ph < 2);
                if (b < 8) e_sda = (m_cmd == C_WRITE) ? !m_tx[7 - b] : 1'b0;
                else       e_sda = (m_cmd == C_WRITE) ? 1'b0 : m_ack;
            end
        endcase
    endtask

    // Model: command acceptance, per-cycle expectations, completion results
    initial begin
        m_st = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st = 0; e_scl = 0; e_sda = 0; e_ready = 1; e_busy = 0;
                e_done = 0; e_data = 8'h00; e_ackr = 0;
            end else if (m_st == 0) begin
                if (cmd_valid) begin
                    m_cmd = cmd; m_tx = data_in; m_ack = ack_in; m_k = 0;
                    m_len = (cmd[1] ? 36 : 4) * P;
                    m_st = 1; e_ready = 0; e_busy = 1;
                    m_lines(0);
                end
            end else if (m_st == 1) begin
                m_k++;
                if (m_k == m_len) begin
                    m_st = 2; e_done = 1;
                    case (m_cmd)
                        C_START: begin e_scl = 1; e_sda = 1; end
                        C_STOP:  begin e_scl = 0; e_sda = 0; end
                        C_WRITE: e_ackr = slave_ack;
                        default: e_data = slave_byte;
                    endcase
                end else begin
                    m_lines(m_k);
                end
            end else begin
                m_st = 0; e_done = 0; e_ready = 1; e_busy = 0;
            end
        end
    end

    // Slave: drives read data bits and the write ACK while SCL is low
    initial begin
        slave_low = 1'b0;
        forever begin
            @(negedge clk);
            if (m_st == 1 && m_cmd == C_READ && (m_k / (4 * P)) < 8)
                slave_low = !slave_byte[7 - m_k / (4 * P)];
            else if (m_st == 1 && m_cmd == C_WRITE && (m_k / (4 * P)) == 8)
                slave_low = slave_ack;
            else
                slave_low = 1'b0;
        end
    end

    // Capture master SDA drive at each SCL release and SCL state when SDA is released
    initial begin
        cap_prev_scl = 1'b0;
        cap_prev_sda = 1'b0;
        forever begin
            @(negedge clk);
            if (cap_prev_scl && !scl_oe) cap_bits = {cap_bits[7:0], !sda_oe};
            if (cap_prev_sda && !sda_oe) sda_rise_scl = scl_oe;
            if (done === 1'b1) done_cnt++;
            cap_prev_scl = scl_oe;
            cap_prev_sda = sda_oe;
        end
    end

`ifndef I2C_CLOCK_STRETCH_EN
    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("scl_oe", scl_oe, e_scl);
                chk("sda_oe", sda_oe, e_sda);
                chk("cmd_ready", cmd_ready, e_ready);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("data", data_out, e_data);
                chk("ack_received", ack_rx, e_ackr);
            end
        end
    end
`endif

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                           input int stretch_at, input int inject_at, output int lat);
        int n;
        int rel;
        int hold_left;
        logic prev;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("ready_timeout", cmd_ready, 1);
        cmd = c; data_in = d; ack_in = a; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; rel = 0; hold_left = 0; prev = scl_oe;
        while (done !== 1'b1 && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                cmd = C_READ;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) scl_hold = 1'b0;
            end
            if (prev && !scl_oe) begin
                rel++;
                if (rel == stretch_at) begin
                    scl_hold = 1'b1;
                    hold_left = 20;
                end
            end
            prev = scl_oe;
        end
        cmd_valid = 1'b0;
        chk("done_seen", done, 1);
    endtask

    initial begin
        int lat;
        int lat0;
        int lat1;
        int d0;
        rst = 1; cmd_valid = 0; cmd = 2'b00; data_in = 8'h00; ack_in = 0;
        scl_hold = 0; cmp_en = 0; slave_byte = 8'h00; slave_ack = 0;
        cap_bits = 9'h0; sda_rise_scl = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_ack", ack_rx, 0);
        rst = 0;

        run_cmd(C_START, 8'h00, 1'b0, 0, 0, lat);
        chk("start_latency", lat, 4 * P + 1);

        // WRITE 0xA5, slave ACKs: done 144 cycles after phase start
        slave_ack = 1; cap_bits = 9'h0;
        run_cmd(C_WRITE, 8'hA5, 1'b0, 0, 0, lat);
        chk("write_latency", lat, 145);
        chk("write_a5_bits", cap_bits, 9'h14B);
        chk("write_ack", ack_rx, 1);

        // READ 0x3C with NACK
        slave_byte = 8'h3C; cap_bits = 9'h0;
        run_cmd(C_READ, 8'hFF, 1'b0, 0, 0, lat);
        chk("read_latency", lat, 145);
        chk("read_data", data_out, 8'h3C);
        chk("read_nack_sda", cap_bits, 9'h1FF);

        // READ pulsed during a busy WRITE is ignored
        d0 = done_cnt;
        run_cmd(C_WRITE, 8'h5A, 1'b0, 0, 30, lat);
        repeat (3) @(negedge clk);
        chk("ignored_done_count", done_cnt - d0, 1);
        chk("ignored_data", data_out, 8'h3C);

        // WRITE 0x00, no ACK from slave
        slave_ack = 0; cap_bits = 9'h0;
        run_cmd(C_WRITE, 8'h00, 1'b0, 0, 0, lat);
        chk("write_nack", ack_rx, 0);
        chk("write_00_bits", cap_bits, 9'h001);

        // STOP: SDA released while SCL released, both idle at end
        sda_rise_scl = 1'b1;
        run_cmd(C_STOP, 8'h00, 1'b0, 0, 0, lat);
        chk("stop_sda_rise_scl_high", sda_rise_scl, 0);
        chk("stop_scl_end", scl_oe, 0);
        chk("stop_sda_end", sda_oe, 0);

        // Clock stretch in bit 3 phase 2
        slave_ack = 1;
        run_cmd(C_START, 8'h00, 1'b0, 0, 0, lat);
        run_cmd(C_WRITE, 8'hA5, 1'b0, 0, 0, lat0);
        run_cmd(C_WRITE, 8'hA5, 1'b0, 4, 0, lat1);
`ifdef I2C_CLOCK_STRETCH_EN
        chk("stretch_delay_min", (lat1 - lat0) >= 20, 1);
        chk("stretch_delay_max", (lat1 - lat0) <= 22, 1);
`else
        chk("stretch_no_delay", lat1, lat0);
`endif

        // Reset at bit 4 of a WRITE
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd = C_WRITE; data_in = 8'h55; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (70) @(negedge clk);
        rst = 1;
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        rst = 0;
        repeat (200) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

        run_cmd(C_START, 8'h00, 1'b0, 0, 0, lat);
        chk("recover_start_latency", lat, 4 * P + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
